sw_handshake_driver: RTL and testbench
======================================

// Module: sw_handshake_driver
// PURPOSE
//  Host-side partner of the picoMips switch/LED interface: feeds a byte stream into the
//  core's SW[7:0] with the SW[8] handshake, drives core reset SW[9], captures LED after
//  each transfer. Sits between a byte source (valid/ready) and the picoMips top, giving
//  benches/demos a timed, repeatable replacement for manual switch operation.
// PARAMETERS
//  DEPTH         4   input FIFO entries (power of 2, >=2)
//  HOLD_CYCLES   16  cycles SW[8] held high per byte (>=1; core stalls up to 4 stages/instr)
//  GAP_CYCLES    16  cycles SW[8] held low after each byte before LED capture (>=1)
//  CNT_W         8   timer width; HOLD_CYCLES,GAP_CYCLES < 2**CNT_W
// PORTS
//  Clock        in   1      single clock, all state on rising edge
//  nReset       in   1      asynchronous, active-low reset
//  CoreEnable   in   1      1 = release core from reset (drives SW[9])
//  InValid      in   1      byte offered
//  InReady      out  1      FIFO not full; byte accepted when InValid&InReady
//  InData       in   8      byte to present on SW[7:0]
//  SW           out  10     to picoMips: [9]=core nReset, [8]=handshake, [7:0]=data
//  LED          in   8      from picoMips accumulator
//  ResultValid  out  1      one-cycle pulse, ResultData valid
//  ResultData   out  8      LED sampled at end of gap (signed, passed unchanged)
//  Busy         out  1      FSM not IDLE or FIFO not empty
// BEHAVIOUR
//  - Reset: SW=0, ResultValid=0, ResultData=0, Busy=0, InReady=1, FIFO empty, FSM IDLE.
//  - SW[9] = CoreEnable registered once (1-cycle latency); clears async with nReset.
//  - FIFO: push on InValid&InReady; pop on IDLE->SETUP; wrap-around pointers with
//    extra MSB for full/empty; push and pop same cycle when full allowed (count unchanged);
//    push ignored when full (InReady=0).
//  - FSM (advances only while SW[9]==1):
//    IDLE:    FIFO non-empty -> SETUP, pop head into SW[7:0].
//    SETUP:   1 cycle, SW[8]=0, data stable (setup time) -> ASSERT, timer=0.
//    ASSERT:  SW[8]=1 for exactly HOLD_CYCLES cycles -> RELEASE, timer=0.
//    RELEASE: SW[8]=0 for exactly GAP_CYCLES cycles; in last cycle ResultData<=LED,
//             ResultValid pulses next cycle -> IDLE.
//  - SW[7:0] holds the last presented byte until the next pop (never glitches mid-handshake).
//  - Back-to-back bytes: IDLE lasts 1 cycle; period per byte = 2+HOLD+GAP cycles.
//  - CoreEnable low mid-transfer: next cycle SW[9]=0 and FSM -> IDLE, SW[8]=0, in-flight
//    byte discarded, no ResultValid; FIFO contents kept and resume when re-enabled.
//  - CoreEnable low while IDLE: FIFO still accepts pushes; nothing presented.
//  - Timers saturate-free: compare timer==N-1 then clear; no wrap within a state.
//  - ResultData retains last value between pulses.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE,SETUP,ASSERT,RELEASE), SW bit-index constants
//    (SW_NRESET=9, SW_HS=8), data width constant 8 shared with the core top.
//  - One sub-module: byte_fifo (DEPTH, 8-bit, push/pop/full/empty); FSM+timers in top.
// TESTING
//  1 Reset: nReset=0 mid-ASSERT -> SW=0, ResultValid=0, Busy=0, FIFO empty immediately.
//  2 Single byte 8'h2A, CoreEnable=1, HOLD=16, GAP=16 -> SW[7:0]=2A; SW[8] high exactly
//    16 cycles starting 2 cycles after push; ResultValid 1 pulse with ResultData=LED model.
//  3 Push 5 bytes 01..05 with DEPTH=4 -> InReady=0 after 4th until first pop; all 5
//    presented in order, 5 ResultValid pulses spaced 34 cycles.
//  4 Push while full and pop same cycle -> accepted, ordering preserved, no loss.
//  5 CoreEnable=0 during ASSERT of byte 8'h10 (8'h11 queued) -> SW[9]=0, SW[8]=0 next
//    cycle, no result; re-enable -> 8'h11 presented next, 8'h10 never re-sent.
//  6 CoreEnable=0, push 8'h7F -> nothing driven, Busy=1; enable -> normal transfer.

Source files
------------

// File: rtl/sw_handshake_driver_pkg.sv
// Shared definitions for the host-side picoMips switch/LED handshake driver.
// The switch-bus layout and data width match the core top.
package sw_handshake_driver_pkg;

  localparam int DATA_W    = 8;
  localparam int SW_W      = 10;
  localparam int SW_NRESET = 9;
  localparam int SW_HS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/sw_handshake_driver_byte_fifo.sv
// Small byte FIFO with wrap-around pointers; the extra pointer MSB separates full from empty.
// A push while full is taken only when a pop happens in the same cycle.
module sw_handshake_driver_byte_fifo
  import sw_handshake_driver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sw_handshake_driver.sv
// Feeds queued bytes to the picoMips SW bus with a timed SW[8] handshake,
// drives the core reset from CoreEnable and captures LED at the end of each gap.
module sw_handshake_driver
  import sw_handshake_driver_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 16,
  parameter int CNT_W       = 8
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              CoreEnable,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic [SW_W-1:0]   SW,
  input  logic [DATA_W-1:0] LED,
  output logic              ResultValid,
  output logic [DATA_W-1:0] ResultData,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              core_en_q, core_en_d;
  logic              hs_q, hs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_vld_q, res_vld_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sw_handshake_driver_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (Clock),
    .rst_n  (nReset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_data(InData),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    data_d     = data_q;
    res_data_d = res_data_q;
    res_vld_d  = 1'b0;
    fifo_pop   = 1'b0;
    core_en_d  = CoreEnable;

    // Dropping CoreEnable abandons the in-flight byte in the same edge that resets the core.
    if (!CoreEnable) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (core_en_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_head;
            state_d  = ST_SETUP;
          end
        end
        ST_SETUP: begin
          state_d = ST_ASSERT;
          timer_d = '0;
        end
        ST_ASSERT: begin
          if (timer_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (timer_q == GAP_LAST) begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            res_data_d = LED;
            res_vld_d  = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    hs_d      = (state_d == ST_ASSERT);
    InReady   = !fifo_full || fifo_pop;
    fifo_push = InValid && InReady;
    Busy      = (state_q != ST_IDLE) || !fifo_empty;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      core_en_q  <= 1'b0;
      hs_q       <= 1'b0;
      data_q     <= '0;
      res_data_q <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      core_en_q  <= core_en_d;
      hs_q       <= hs_d;
      data_q     <= data_d;
      res_data_q <= res_data_d;
      res_vld_q  <= res_vld_d;
    end
  end

  always_comb begin
    SW                = '0;
    SW[SW_NRESET]     = core_en_q;
    SW[SW_HS]         = hs_q;
    SW[DATA_W-1:0]    = data_q;
    ResultValid       = res_vld_q;
    ResultData        = res_data_q;
  end

endmodule

// File: tb/tb_sw_handshake_driver.sv
// Scoreboard bench for sw_handshake_driver with a stub core that answers ~SW[7:0] on LED.
module tb_sw_handshake_driver;

  localparam int DEPTH  = 4;
  localparam int HOLD   = 16;
  localparam int GAP    = 16;
  localparam int PERIOD = 2 + HOLD + GAP;

  logic       Clock      = 1'b0;
  logic       nReset     = 1'b0;
  logic       CoreEnable = 1'b0;
  logic       InValid    = 1'b0;
  logic [7:0] InData     = 8'h00;
  logic       InReady;
  logic [9:0] SW;
  logic [7:0] LED;
  logic       ResultValid;
  logic [7:0] ResultData;
  logic       Busy;

  sw_handshake_driver #(
    .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8)
  ) dut (
    .Clock(Clock), .nReset(nReset), .CoreEnable(CoreEnable),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .SW(SW), .LED(LED), .ResultValid(ResultValid),
    .ResultData(ResultData), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Stub core: while running and the strobe is low, the accumulator shows ~byte.
  assign LED = (SW[9] && !SW[8]) ? ~SW[7:0] : 8'h00;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_present[$];
  logic [7:0] exp_result[$];
  int         rv_times[$];
  int         last_rise_cyc = 0;
  int         accept_cyc = 0;
  logic [7:0] last_presented = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic monitor();
    logic       prev_hs = 1'b0;
    logic       prev_rv = 1'b0;
    int         hs_len = 0;
    logic [7:0] rise_byte = 8'h00;
    logic [7:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (!nReset) begin
        prev_hs = 1'b0;
        prev_rv = 1'b0;
        hs_len  = 0;
      end else begin
        if (SW[8] && !prev_hs) begin
          last_rise_cyc = cyc;
          rise_byte     = SW[7:0];
          if (exp_present.size() == 0) begin
            fail_now("present_byte", $sformatf("byte %02h strobed with none expected", SW[7:0]));
          end else begin
            e = exp_present.pop_front();
            last_presented = e;
            chk("present_byte", SW[7:0], e);
          end
        end
        if (SW[8]) hs_len++;
        if (!SW[8] && prev_hs) begin
          chk("data_stable", SW[7:0], rise_byte);
          if (SW[9]) chk("hs_length", hs_len, HOLD);
          hs_len = 0;
        end
        if (ResultValid) begin
          chk("rv_single_pulse", prev_rv, 1'b0);
          if (exp_result.size() == 0) begin
            fail_now("result_data", $sformatf("result %02h with none expected", ResultData));
          end else begin
            e = exp_result.pop_front();
            chk("result_data", ResultData, e);
          end
          rv_times.push_back(cyc);
        end
        prev_hs = SW[8];
        prev_rv = ResultValid;
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input int budget);
    int w = 0;
    @(negedge Clock);
    InValid = 1'b1;
    InData  = b;
    while (!InReady && w < budget) begin
      @(negedge Clock);
      w++;
    end
    if (!InReady) begin
      fail_now("push_timeout", $sformatf("byte %02h never accepted", b));
      InValid = 1'b0;
    end else begin
      @(posedge Clock);
      #1;
      accept_cyc = cyc;
      InValid = 1'b0;
      exp_present.push_back(b);
      exp_result.push_back(~b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int w = 0;
    while ((exp_result.size() != 0 || Busy) && w < budget) begin
      tick(1);
      w++;
    end
    tick(2);
    n_cmp++;
    if (exp_result.size() != 0 || Busy) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding busy=%0b required 0/0", exp_result.size(), Busy);
    end
  endtask

  task automatic wait_hs(input int budget);
    int w = 0;
    while (!SW[8] && w < budget) begin
      tick(1);
      w++;
    end
    if (!SW[8]) fail_now("hs_timeout", "strobe never rose");
  endtask

  initial begin
    logic [7:0] b;
    fork
      monitor();
    join_none

    tick(3);
    chk("reset_sw", SW, 10'h000);
    chk("reset_rv", ResultValid, 1'b0);
    chk("reset_rdata", ResultData, 8'h00);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_inready", InReady, 1'b1);

    @(negedge Clock);
    nReset = 1'b1;
    CoreEnable = 1'b1;
    tick(3);
    chk("enable_sw9", SW[9], 1'b1);

    // Single byte
    push(8'h2A, 10);
    wait_drain(200);
    chk("t2_rise_latency", last_rise_cyc - accept_cyc, 2);
    chk("t2_data_held", SW[7:0], 8'h2A);

    // Fill while the core is held, then push into a full FIFO alongside the first pop
    @(negedge Clock);
    CoreEnable = 1'b0;
    tick(2);
    for (int i = 1; i <= 4; i++) push(8'(i), 10);
    tick(1);
    chk("t3_full_inready", InReady, 1'b0);
    chk("t3_busy_disabled", Busy, 1'b1);
    chk("t3_nothing_driven", SW[9:8], 2'b00);
    rv_times.delete();
    fork
      push(8'h05, 50);
      begin
        repeat (4) @(negedge Clock);
        CoreEnable = 1'b1;
      end
    join
    chk("t4_full_after_swap", InReady, 1'b0);
    wait_drain(400);
    chk("t3_result_count", rv_times.size(), 5);
    for (int i = 1; i < rv_times.size(); i++)
      chk("t3_spacing", rv_times[i] - rv_times[i-1], PERIOD);

    // Abort mid-strobe
    push(8'h10, 10);
    push(8'h11, 10);
    wait_hs(20);
    tick(5);
    @(negedge Clock);
    CoreEnable = 1'b0;
    void'(exp_result.pop_front());
    tick(1);
    chk("t5_sw9_low", SW[9], 1'b0);
    chk("t5_sw8_low", SW[8], 1'b0);
    chk("t5_busy_queued", Busy, 1'b1);
    tick(40);
    @(negedge Clock);
    CoreEnable = 1'b1;
    wait_drain(200);
    chk("t5_resumed_byte", last_presented, 8'h11);

    // Push while held
    @(negedge Clock);
    CoreEnable = 1'b0;
    tick(2);
    push(8'h7F, 10);
    tick(3);
    chk("t6_busy", Busy, 1'b1);
    chk("t6_sw_idle", SW, {2'b00, 8'h11});
    chk("t6_no_result", ResultValid, 1'b0);
    @(negedge Clock);
    CoreEnable = 1'b1;
    wait_drain(200);
    chk("t6_presented", last_presented, 8'h7F);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      push(b, 100);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 40)) @(negedge Clock);
    end
    wait_drain(3000);
    chk("present_drained", exp_present.size(), 0);

    // Asynchronous reset mid-strobe with a byte still queued
    push(8'h5A, 10);
    push(8'h3C, 10);
    wait_hs(20);
    tick(4);
    #2 nReset = 1'b0;
    #1;
    chk("t1_reset_sw", SW, 10'h000);
    chk("t1_reset_rv", ResultValid, 1'b0);
    chk("t1_reset_busy", Busy, 1'b0);
    chk("t1_reset_inready", InReady, 1'b1);
    exp_present.delete();
    exp_result.delete();
    tick(2);
    @(negedge Clock);
    nReset = 1'b1;
    tick(6);
    chk("t1_fifo_empty_after", Busy, 1'b0);
    chk("t1_no_strobe_after", SW[8], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
